led_sched: RTL
==============

# led_sched

Round-robin scheduler that shares the board's single status LED between several requesters. Each requester asks for a burst of blinks. The block grants the LED to one requester at a time, drives the blink waveform from a fixed on/off cycle budget, and signals completion. It sits between the status sources and the LED pin, replacing the free-running `led` driver when more than one agent needs the LED.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `ON_CYC`, 4, clock cycles the LED is lit per blink (>=1)
- `OFF_CYC`, 4, clock cycles the LED is dark after each blink (>=1)
- `CNT_W`, 4, width of each requester's blink count
- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `req`  in  N_REQ  per-requester request level
- `blinks`  in  N_REQ*CNT_W  packed blink counts; requester i at [i*CNT_W +: CNT_W]
- `grant`  out  N_REQ  one-hot owner of the LED, registered; 0 when idle
- `done`  out  N_REQ  one-cycle completion pulse, one-hot
- `led`  out  1  LED drive, registered
- `busy`  out  1  high whenever a burst is in progress

## Operation
- FSM states: IDLE, ON, OFF. Internal state:
  - round-robin pointer `ptr` (0..N_REQ-1)
  - latched `remaining` count (CNT_W bits)
  - phase counter wide enough for max(ON_CYC, OFF_CYC)
- Eligibility: requester i is eligible when req[i]=1 and its blinks field is nonzero. Zero-count requesters are masked and are never granted.
- IDLE:
  - Winner is the first eligible index at or after `ptr`, wrapping modulo N_REQ.
  - If a winner exists, on the next edge:
    - grant = onehot(winner)
    - remaining = blinks[winner]
    - state -> ON
  - If no winner exists, the block stays in IDLE.
- ON: led=1 for exactly ON_CYC cycles, then state -> OFF.
- OFF:
  - led=0 for exactly OFF_CYC cycles.
  - On the last OFF cycle, remaining is decremented.
  - If the result is 0, state -> IDLE; otherwise state -> ON.
- On entry to IDLE after a burst:
  - done[winner]=1 for that single cycle
  - grant=0
  - ptr = (winner+1) mod N_REQ
- The blink count is sampled only in the grant cycle. Changes to req or blinks during a burst are ignored, and the burst always completes.
- A requester whose req is still high in its done cycle stays eligible. It is re-granted there only if no other eligible requester precedes it in round-robin order.
- led = (state==ON). busy = (state!=IDLE). grant is constant for the whole burst.

## Timing
- Reset values: state=IDLE, ptr=0, grant=0, done=0, led=0, busy=0, remaining=0, phase counter=0.
- Reset taken at any point, including mid-burst: on the next edge all of the above hold. No done pulse is issued for the aborted burst.
- Arbitration latency: request sampled in IDLE cycle t -> grant, led and busy all high at cycle t+1.
- A burst of B blinks holds grant for B*(ON_CYC+OFF_CYC) cycles.
- done asserts in the first cycle after grant drops. Arbitration also happens in that same IDLE cycle, using the updated ptr.
- Minimum gap between consecutive bursts is one IDLE cycle, the done cycle. Round-robin period for continuous requests is B*(ON_CYC+OFF_CYC)+1.
- Pointer wrap: winner N_REQ-1 -> ptr=0.
- Max count: blinks = 2^CNT_W-1 is legal and must not overflow.

## Test plan
- **Reset:** req=1111, all blinks=1, rst high for cycles 0-1. Required: grant=0, done=0, led=0, busy=0 through cycle 2. First grant=0001 in cycle 3.
- **Single requester:** defaults, req=0100, blinks[2]=3, sampled in cycle 0. Required:
  - grant=0100 in cycles 1-24
  - led=1 in cycles 1-4, 9-12, 17-20, and 0 elsewhere
  - done=0100 in cycle 25 only; busy=0 in cycle 25
- **Round robin:** req=1111, all blinks=1, held high. Required:
  - grants in order 0001, 0010, 0100, 1000, 0001
  - each grant lasts 8 cycles, and bursts start 9 cycles apart
  - each done pulse coincides with the IDLE gap
- **Zero-count mask:** req=0011, blinks[0]=0, blinks[1]=2. Required: only 0010 is granted (16 cycles), done[0] is never asserted, and the block stays IDLE afterward while req[1]=0.
- **Mid-burst input change:** grant requester 1 with blinks=2. At cycle 5 drop req[1] and set blinks[1]=7. Required: the burst still runs 16 cycles, and exactly one done[1] pulse follows.
- **Reset mid-burst:**
  - While requester 2 is in cycle 6 of its burst, pulse rst for one cycle. Required: all outputs 0 on the next edge, with no done pulse.
  - Then apply req=1111. Required: grant=0001 first, confirming ptr=0.

Source files
------------

// File: rtl/led_sched_if.sv
// Request/grant bundle between the status sources and the LED scheduler.
// The sources drive req/blinks; the scheduler answers with grant/done/led/busy.
interface led_sched_if #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 4
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*CNT_W-1:0] blinks;
    logic [N_REQ-1:0]       grant;
    logic [N_REQ-1:0]       done;
    logic                   led;
    logic                   busy;

    modport master (
        output req, blinks,
        input  grant, done, led, busy
    );

    modport slave (
        input  req, blinks,
        output grant, done, led, busy
    );
endinterface

// File: rtl/led_sched.sv
// Round-robin owner of the single status LED: grants one requester at a time,
// plays its burst of fixed-length on/off blinks, then pulses done for it.
module led_sched #(
    parameter int N_REQ   = 4,
    parameter int ON_CYC  = 4,
    parameter int OFF_CYC = 4,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        rst,
    led_sched_if.slave  bus
);

    localparam int PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int PH_MAX = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    localparam logic [PH_W-1:0] ON_LAST  = PH_W'(ON_CYC - 1);
    localparam logic [PH_W-1:0] OFF_LAST = PH_W'(OFF_CYC - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic [PH_W-1:0]    phase_q, phase_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [N_REQ-1:0]   done_q, done_d;

    logic [CNT_W-1:0]   counts [N_REQ];
    logic [N_REQ-1:0]   eligible;
    logic               win_found;
    logic [PTR_W-1:0]   win_idx;

    // Index base+offset, wrapped into 0..N_REQ-1 (N_REQ need not be a power of two).
    function automatic logic [PTR_W-1:0] rr_index(input logic [PTR_W-1:0] base, input int offset);
        int s;
        s = int'(base) + offset;
        if (s >= N_REQ) s = s - N_REQ;
        return s[PTR_W-1:0];
    endfunction

    // A zero-count request is masked so it can never hold the LED for nothing.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            counts[i]   = bus.blinks[i*CNT_W +: CNT_W];
            eligible[i] = bus.req[i] && (counts[i] != '0);
        end
    end

    // Scan from the farthest offset down so the closest eligible index at or after ptr wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (eligible[rr_index(ptr_q, k)]) begin
                win_found = 1'b1;
                win_idx   = rr_index(ptr_q, k);
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments only, so every flop
    // samples the pre-edge values and process order cannot change the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            remaining_q <= '0;
            phase_q     <= '0;
            grant_q     <= '0;
            done_q      <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            remaining_q <= remaining_d;
            phase_q     <= phase_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
        end
    end

    // NOTE: every variable gets a default at the top of the block; without it a
    // path that skips an assignment would infer a latch.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        remaining_d = remaining_q;
        phase_d     = phase_q;
        grant_d     = grant_q;
        done_d      = '0;

        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d          = ON;
                    owner_d          = win_idx;
                    remaining_d      = counts[win_idx];
                    phase_d          = '0;
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                end
            end

            ON: begin
                if (phase_q == ON_LAST) begin
                    phase_d = '0;
                    state_d = OFF;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end

            OFF: begin
                if (phase_q == OFF_LAST) begin
                    phase_d     = '0;
                    remaining_d = remaining_q - 1'b1;
                    // Last blink of the burst: release the LED and hand the pointer on.
                    if (remaining_q == CNT_W'(1)) begin
                        state_d         = IDLE;
                        grant_d         = '0;
                        done_d[owner_q] = 1'b1;
                        ptr_d           = rr_index(owner_q, 1);
                    end else begin
                        state_d = ON;
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_comb begin
        bus.grant = grant_q;
        bus.done  = done_q;
        bus.led   = (state_q == ON);
        bus.busy  = (state_q != IDLE);
    end

endmodule
